// File: rtl/pc_source_sequencer_if.sv
// PC update request handshake between the main control unit (master)
// and the PC source sequencer (slave).
interface pc_source_sequencer_if;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;

  modport master (output req_valid, output req_sel, input  req_ready);
  modport slave  (input  req_valid, input  req_sel, output req_ready);
endinterface

// File: rtl/pc_source_sequencer.sv
// Sequences every PC update: one-cycle requests and the multi-cycle exception routine.
// Build option PCSEQ_DIVZERO_EXC_EN enables the divide-by-zero exception (cause 11).
module pc_source_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter int VEC_BASE    = 253
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        exc_opcode,
  input  logic                        exc_overflow,
  input  logic                        exc_divzero,
  pc_source_sequencer_if.slave        req,
  input  logic [7:0]                  mem_byte,
  output logic [1:0]                  PCSourceCtrl,
  output logic                        PC_Write,
  output logic                        EPC_Write,
  output logic                        Exc_Mem_Read,
  output logic [31:0]                 Exc_Addr,
  output logic [1:0]                  Exc_Cause,
  output logic [31:0]                 Exception_Destiny,
  output logic                        busy
);

  localparam logic [2:0]  LAT_W  = 3'(MEM_LATENCY);
  localparam logic [31:0] BASE_W = 32'(VEC_BASE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    XFER     = 3'd1,
    EXC_EPC  = 3'd2,
    EXC_RD   = 3'd3,
    EXC_WAIT = 3'd4,
    EXC_LOAD = 3'd5
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] wait_cnt_r;
  logic       divzero_s;
  logic [1:0] cause_s;
  logic       exc_any_s;
  logic       accept_s;

`ifdef PCSEQ_DIVZERO_EXC_EN
  assign divzero_s = exc_divzero;
`else
  logic unused_divzero_s;
  assign unused_divzero_s = exc_divzero;
  assign divzero_s        = 1'b0;
`endif

  // Fixed-priority cause encoding: opcode > overflow > divzero.
  always_comb begin
    cause_s = 2'b00;
    if (exc_opcode) begin
      cause_s = 2'b01;
    end else if (exc_overflow) begin
      cause_s = 2'b10;
    end else if (divzero_s) begin
      cause_s = 2'b11;
    end else begin
      cause_s = 2'b00;
    end
  end

  assign exc_any_s     = (cause_s != 2'b00);
  assign req.req_ready = accept_s;

  // Next-state decode and request acceptance; exceptions only seen in IDLE.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (exc_any_s) begin
          next_state_s = EXC_EPC;
        end else if (req.req_valid) begin
          accept_s     = 1'b1;
          next_state_s = (req.req_sel != 2'b00) ? XFER : IDLE;
        end else begin
          next_state_s = IDLE;
        end
      end
      XFER:     next_state_s = IDLE;
      EXC_EPC:  next_state_s = EXC_RD;
      EXC_RD:   next_state_s = EXC_WAIT;
      EXC_WAIT: begin
        if (wait_cnt_r <= 3'd1) begin
          next_state_s = EXC_LOAD;
        end else begin
          next_state_s = EXC_WAIT;
        end
      end
      EXC_LOAD: next_state_s = IDLE;
      default:  next_state_s = IDLE;
    endcase
  end

  // State register and memory-latency countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      wait_cnt_r <= 3'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == EXC_RD) begin
        wait_cnt_r <= LAT_W;
      end else if ((state_r == EXC_WAIT) && (wait_cnt_r != 3'd0)) begin
        wait_cnt_r <= wait_cnt_r - 3'd1;
      end
    end
  end

  // Single-cycle strobes, registered from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_Write     <= 1'b0;
      EPC_Write    <= 1'b0;
      Exc_Mem_Read <= 1'b0;
      busy         <= 1'b0;
    end else begin
      PC_Write     <= (next_state_s == XFER) || (next_state_s == EXC_LOAD);
      EPC_Write    <= (next_state_s == EXC_EPC);
      Exc_Mem_Read <= (next_state_s == EXC_RD);
      busy         <= (next_state_s != IDLE);
    end
  end

  // Held datapath values: mux select, cause, vector address and vector byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCSourceCtrl      <= 2'b00;
      Exc_Cause         <= 2'b00;
      Exc_Addr          <= 32'd0;
      Exception_Destiny <= 32'd0;
    end else begin
      if (next_state_s == XFER) begin
        PCSourceCtrl <= req.req_sel;
      end else if (next_state_s == EXC_LOAD) begin
        PCSourceCtrl <= 2'b00;
      end
      if ((state_r == IDLE) && exc_any_s) begin
        Exc_Cause <= cause_s;
        Exc_Addr  <= BASE_W + {30'd0, cause_s} - 32'd1;
      end
      if ((state_r == EXC_WAIT) && (next_state_s == EXC_LOAD)) begin
        Exception_Destiny <= {24'd0, mem_byte};
      end
    end
  end

endmodule

// File: tb/tb_pc_source_sequencer.sv
// Scoreboard bench: a transaction-level model predicts pulse timing and values,
// a negedge monitor compares every PC_Write / EPC_Write / Exc_Mem_Read pulse.
module tb_pc_source_sequencer;
  localparam int LAT = 3;
  localparam int VB  = 253;
  localparam logic [2:0] K_PC  = 3'b100;
  localparam logic [2:0] K_EPC = 3'b010;
  localparam logic [2:0] K_RD  = 3'b001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_opcode = 1'b0, exc_overflow = 1'b0, exc_divzero = 1'b0;
  logic [7:0]  mem_byte = 8'd0;
  logic [1:0]  PCSourceCtrl, Exc_Cause;
  logic        PC_Write, EPC_Write, Exc_Mem_Read, busy;
  logic [31:0] Exc_Addr, Exception_Destiny;

  pc_source_sequencer_if rif();

  pc_source_sequencer #(.MEM_LATENCY(LAT), .VEC_BASE(VB)) dut (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
    .req(rif), .mem_byte(mem_byte),
    .PCSourceCtrl(PCSourceCtrl), .PC_Write(PC_Write), .EPC_Write(EPC_Write),
    .Exc_Mem_Read(Exc_Mem_Read), .Exc_Addr(Exc_Addr), .Exc_Cause(Exc_Cause),
    .Exception_Destiny(Exception_Destiny), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  kind;
    logic [1:0]  src;
    logic [31:0] addr;
    logic [31:0] dest;
    logic [1:0]  cause;
    logic        is_exc;
  } ev_t;

  ev_t         sbq[$];
  int          checks = 0, passes = 0, fails = 0;
  int          free_cyc = 0, plan_cyc = -1;
  logic [7:0]  plan_byte = 8'd0;
  logic [1:0]  exp_src = 2'b00, exp_cause = 2'b00;
  logic        mon_en = 1'b0;
  ev_t         mon_e;
  logic [2:0]  mon_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      passes++;
    end
  endtask

  task automatic push(input int c, input logic [2:0] k, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] ca, input logic ie);
    ev_t e;
    e.cyc = c; e.kind = k; e.src = s; e.addr = a; e.dest = d; e.cause = ca; e.is_exc = ie;
    sbq.push_back(e);
  endtask

  // One clock cycle: apply inputs, predict with the model, check handshake, advance.
  task automatic drive(input logic [2:0] exc, input logic rv, input logic [1:0] rs,
                       input logic [7:0] vbyte, output logic acc);
    logic       idle, dz, exp_ready;
    logic [1:0] cause;
    exc_opcode   = exc[2];
    exc_overflow = exc[1];
    exc_divzero  = exc[0];
    rif.req_valid = rv;
    rif.req_sel   = rs;
    mem_byte = (cyc == plan_cyc) ? plan_byte : 8'($urandom);
    idle = (cyc >= free_cyc);
`ifdef PCSEQ_DIVZERO_EXC_EN
    dz = exc[0];
`else
    dz = 1'b0;
`endif
    cause = exc[2] ? 2'd1 : exc[1] ? 2'd2 : dz ? 2'd3 : 2'd0;
    acc = 1'b0;
    exp_ready = 1'b0;
    if (idle && cause != 2'd0) begin
      push(cyc + 1, K_EPC, 2'b00, 32'd0, 32'd0, cause, 1'b1);
      push(cyc + 2, K_RD, 2'b00, 32'(VB + int'(cause) - 1), 32'd0, cause, 1'b1);
      push(cyc + 3 + LAT, K_PC, 2'b00, 32'd0, {24'd0, vbyte}, cause, 1'b1);
      plan_cyc  = cyc + 2 + LAT;
      plan_byte = vbyte;
      free_cyc  = cyc + 4 + LAT;
    end else if (idle && rv) begin
      acc = 1'b1;
      exp_ready = 1'b1;
      if (rs != 2'b00) begin
        push(cyc + 1, K_PC, rs, 32'd0, 32'd0, 2'b00, 1'b0);
        free_cyc = cyc + 2;
      end else begin
        free_cyc = cyc + 1;
      end
    end
    #1;
    chk("req_ready", rif.req_ready, exp_ready);
    chk("busy", busy, !idle);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(3'b000, 1'b0, 2'b00, 8'd0, acc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_PCSourceCtrl"}, PCSourceCtrl, 32'd0);
    chk({tag, "_PC_Write"}, PC_Write, 32'd0);
    chk({tag, "_EPC_Write"}, EPC_Write, 32'd0);
    chk({tag, "_Exc_Mem_Read"}, Exc_Mem_Read, 32'd0);
    chk({tag, "_Exc_Addr"}, Exc_Addr, 32'd0);
    chk({tag, "_Exc_Cause"}, Exc_Cause, 32'd0);
    chk({tag, "_Exception_Destiny"}, Exception_Destiny, 32'd0);
    chk({tag, "_busy"}, busy, 32'd0);
  endtask

  // Monitor: every strobe must match the oldest predicted event in kind, cycle and data.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL missed_pulse: kind %b due cycle %0d, nothing seen by cycle %0d",
                 sbq[0].kind, sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end
      mon_p = {PC_Write, EPC_Write, Exc_Mem_Read};
      if (mon_p != 3'b000) begin
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          chk("unexpected_pulse", {29'd0, mon_p}, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("pulse_kind", {29'd0, mon_p}, {29'd0, mon_e.kind});
          if (mon_e.kind == K_EPC) exp_cause = mon_e.cause;
          if (mon_e.kind == K_RD) chk("Exc_Addr", Exc_Addr, mon_e.addr);
          if (mon_e.kind == K_PC) begin
            exp_src = mon_e.src;
            if (mon_e.is_exc) chk("Exception_Destiny", Exception_Destiny, mon_e.dest);
          end
        end
      end
      chk("PCSourceCtrl", PCSourceCtrl, {30'd0, exp_src});
      chk("Exc_Cause", Exc_Cause, {30'd0, exp_cause});
    end
  end

  initial begin
    logic       acc;
    logic       pend;
    logic [1:0] psel;
    logic [2:0] ex;
    rif.req_valid = 1'b0;
    rif.req_sel   = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    free_cyc = cyc;
    mon_en = 1'b1;

    // Normal request, Shift_Left_2, then hold.
    drive(3'b000, 1'b1, 2'b11, 8'd0, acc);
    idle_n(3);
    // Invalid opcode with vector byte A4.
    drive(3'b100, 1'b0, 2'b00, 8'hA4, acc);
    idle_n(LAT + 5);
    // Overflow and divzero together with a request; request is retried.
    drive(3'b011, 1'b1, 2'b01, 8'h3E, acc);
    for (int i = 0; i < 20 && !acc; i++) drive(3'b000, 1'b1, 2'b01, 8'd0, acc);
    idle_n(2);
    // Divide-by-zero alone: full routine only when the option is built in.
    drive(3'b001, 1'b0, 2'b00, 8'h77, acc);
    idle_n(LAT + 5);
    // Illegal select: consumed with no PC write.
    drive(3'b000, 1'b1, 2'b00, 8'd0, acc);
    idle_n(2);

    // Abandon a routine mid-flight with asynchronous reset.
    drive(3'b010, 1'b0, 2'b00, 8'h5C, acc);
    idle_n(2);
    #1;
    reset = 1'b0;
    sbq.delete();
    exp_src = 2'b00;
    exp_cause = 2'b00;
    plan_cyc = -1;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    free_cyc = cyc;
    idle_n(LAT + 6);

    // Randomized traffic; a pending request is held until accepted.
    pend = 1'b0;
    psel = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        psel = 2'($urandom);
      end
      ex = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      drive(ex, pend, pend ? psel : 2'($urandom), 8'($urandom), acc);
      if (acc) pend = 1'b0;
    end
    idle_n(LAT + 8);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_source_sequencer.md
# pc_source_sequencer

- Sequences every update of the program counter.
- Drives the 2-bit PC source select of the PC source mux, the PC and EPC write enables, and the exception-vector memory read.
- On an exception it runs a fixed multi-cycle routine: save EPC, read the vector byte, load PC.
- Otherwise it services one-cycle PC update requests from the main control unit.

## Interface
Parameters:
- MEM_LATENCY, 1, cycles from Exc_Mem_Read to valid mem_byte (legal range 1–7).
- VEC_BASE, 253, byte address of the first exception vector.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- exc_opcode  in  1  invalid-opcode exception request.
- exc_overflow  in  1  ALU overflow exception request.
- exc_divzero  in  1  divide-by-zero exception request.
- req_valid  in  1  main control requests a PC update.
- req_sel  in  2  requested source: 01 EPC, 10 ALU_Out, 11 Shift_Left_2; 00 illegal.
- req_ready  out  1  request accepted this cycle (combinational).
- mem_byte  in  8  byte returned by memory for the vector read.
- PCSourceCtrl  out  2  select to the PC source mux (registered).
- PC_Write  out  1  PC load enable (registered).
- EPC_Write  out  1  EPC load enable; EPC captures ALU_Out = PC-4 (registered).
- Exc_Mem_Read  out  1  memory read strobe for the vector fetch (registered).
- Exc_Addr  out  32  vector address (registered).
- Exc_Cause  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 divzero.
- Exception_Destiny  out  32  zero-extended vector byte, mux input 00.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
States: IDLE, XFER, EXC_EPC, EXC_RD, EXC_WAIT, EXC_LOAD.

- **IDLE, exception present:**
  - Any exc_* high: latch Exc_Cause by priority opcode > overflow > divzero.
  - Go to EXC_EPC; req_ready = 0.
- **IDLE, request only:**
  - No exception and req_valid with req_sel ≠ 00: req_ready = 1, latch req_sel, go to XFER.
  - req_sel = 00: req_ready = 1, request consumed, state stays IDLE, no PC_Write.
- **XFER:** PCSourceCtrl = latched sel, PC_Write = 1 for one cycle, then IDLE.
- **EXC_EPC:**
  - EPC_Write = 1 for one cycle.
  - Exc_Addr = VEC_BASE + Exc_Cause − 1 (253/254/255 at default).
  - Go to EXC_RD.
- **EXC_RD:** Exc_Mem_Read = 1 for one cycle, load the wait counter with MEM_LATENCY, go to EXC_WAIT.
- **EXC_WAIT:**
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, capture Exception_Destiny = {24'b0, mem_byte} and go to EXC_LOAD.
- **EXC_LOAD:**
  - PCSourceCtrl = 00, PC_Write = 1 for one cycle.
  - Go to IDLE; Exc_Cause holds its value until the next exception.
- **Outside IDLE:**
  - exc_* and req_valid are ignored (no nesting); req_ready = 0.
  - Requesters must hold req_valid until it is accepted.
- PCSourceCtrl holds its last driven value when not writing. PC_Write, EPC_Write and Exc_Mem_Read are single-cycle pulses.

## Timing
- **Reset** (asynchronous, any state):
  - State returns to IDLE.
  - All outputs go to 0: PCSourceCtrl = 00, Exc_Addr = 0, Exception_Destiny = 0, Exc_Cause = 00, busy = 0.
  - An in-flight routine is abandoned with no further write pulses.
- **Normal request:** accepted in cycle n; PC_Write asserted in cycle n+1; back-to-back accept possible in n+2.
- **Exception, MEM_LATENCY=1:**

  | Cycle | State | Action |
  |---|---|---|
  | 0 | IDLE | detect |
  | 1 | EXC_EPC | EPC_Write |
  | 2 | EXC_RD | Exc_Mem_Read |
  | 3 | EXC_WAIT | capture mem_byte |
  | 4 | EXC_LOAD | PC_Write, PCSourceCtrl = 00 |
  | 5 | IDLE | — |

- **Exception latency in general:** PC_Write arrives 3 + MEM_LATENCY cycles after detection.
- **Simultaneous events:**
  - Exception and req_valid in the same IDLE cycle: the exception wins, and the request is retried later.
  - Multiple exc_* inputs high: resolved by fixed priority.

## Configuration
- PCSEQ_DIVZERO_EXC_EN:
  - Defined: exc_divzero participates as described, cause 11, vector VEC_BASE+2.
  - Undefined: exc_divzero is ignored entirely and cause 11 is never produced. The port still exists.

## Test plan
- **Reset mid-routine:** release reset, then pulse exc_overflow; assert reset in cycle 3.
  - All outputs 0 immediately and busy = 0.
  - No PC_Write afterward.
- **Normal request:** req_valid = 1, req_sel = 11 in IDLE.
  - req_ready = 1 that cycle.
  - Next cycle PC_Write = 1, PCSourceCtrl = 11.
  - Then idle with PCSourceCtrl held at 11.
- **Invalid opcode:** exc_opcode = 1, mem_byte = 8'hA4 at default parameters.
  - EPC_Write in cycle 1.
  - Exc_Mem_Read with Exc_Addr = 253 in cycle 2.
  - Exception_Destiny = 32'h000000A4.
  - PC_Write with PCSourceCtrl = 00 in cycle 4; Exc_Cause = 01.
- **Simultaneous exceptions and request:** exc_overflow = exc_divzero = 1 together with req_valid = 1.
  - req_ready = 0.
  - Exc_Cause = 10, Exc_Addr = 254.
  - The request is accepted only after return to IDLE.
- **Memory latency:** MEM_LATENCY = 3, exc_divzero with PCSEQ_DIVZERO_EXC_EN defined.
  - Exc_Addr = 255.
  - PC_Write 6 cycles after detection.
  - Repeat without the macro: no response, busy stays 0.
- **Exception return and illegal request:** req_sel = 01 gives PCSourceCtrl = 01 with a PC_Write pulse. req_sel = 00 gives req_ready = 1 and no PC_Write.
